// File: rtl/spart_echo_ctrl_if.sv
// SPART register-bus handshake: strobes and address from the host controller,
// receive/transmit status flags from the SPART.
interface spart_echo_ctrl_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, iorw, ioaddr, input rda, tbr);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_echo_ctrl.sv
// SPART host controller: programs the baud divisor, then echoes every received
// byte back through a small FIFO. Optional ASCII case swap, overrun counting.
// databus stays a plain inout port so the tristate resolution is explicit at
// the level where the controller and the SPART both drive it.
module spart_echo_ctrl #(
    parameter int CLK_HZ     = 50000000,
    parameter int FIFO_DEPTH = 4,
    parameter int CASE_SWAP  = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   br_cfg,
    spart_echo_ctrl_if.master            bus,
    inout  wire  [7:0]                   databus,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic [7:0]                   overrun_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {INIT, DBL, DBH, RUN, RD, WR, GAP} state_t;

    state_t         state;
    logic [1:0]     cfg_q;
    logic           iocs_q, iorw_q, drive_q, discard_q;
    logic [1:0]     ioaddr_q;
    logic [7:0]     dout_q;
    logic [7:0]     overrun_q;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           full, empty, push, pop;
    logic [15:0]    div_sel;

    // Divisor for a baud select: CLK_HZ/(16*baud) - 1, baud = 4800 << sel.
    function automatic logic [15:0] div_of(input logic [1:0] sel);
        int baud;
        baud = 4800 << sel;
        return 16'(CLK_HZ / (16 * baud) - 1);
    endfunction

    // Flip bit 5 of ASCII letters when case swap is enabled.
    function automatic logic [7:0] swap_case(input logic [7:0] b);
        if (CASE_SWAP != 0 &&
            ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)))
            return b ^ 8'h20;
        return b;
    endfunction

    // Low byte is launched on entry to DBL (from live br_cfg, latched at the
    // same edge); high byte on entry to DBH, from the latched cfg_q.
    assign div_sel = div_of(state == DBL ? cfg_q : br_cfg);

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign push  = (state == RD) && !discard_q;
    assign pop   = (state == WR);

    assign bus.iocs    = iocs_q;
    assign bus.iorw    = iorw_q;
    assign bus.ioaddr  = ioaddr_q;
    assign databus     = drive_q ? dout_q : 8'hzz;
    assign fifo_count  = count;
    assign overrun_cnt = overrun_q;

    // Bus sequencer; outputs are registered alongside the next state so they
    // always describe the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            cfg_q     <= 2'b00;
            iocs_q    <= 1'b0;
            iorw_q    <= 1'b1;
            ioaddr_q  <= 2'b00;
            drive_q   <= 1'b0;
            dout_q    <= 8'h00;
            discard_q <= 1'b0;
            overrun_q <= 8'h00;
        end else begin
            iocs_q   <= 1'b0;
            iorw_q   <= 1'b1;
            ioaddr_q <= 2'b00;
            drive_q  <= 1'b0;
            case (state)
                INIT: begin
                    state    <= DBL;
                    cfg_q    <= br_cfg;
                    iocs_q   <= 1'b1;
                    iorw_q   <= 1'b0;
                    ioaddr_q <= 2'b10;
                    drive_q  <= 1'b1;
                    dout_q   <= div_sel[7:0];
                end
                DBL: begin
                    state    <= DBH;
                    iocs_q   <= 1'b1;
                    iorw_q   <= 1'b0;
                    ioaddr_q <= 2'b11;
                    drive_q  <= 1'b1;
                    dout_q   <= div_sel[15:8];
                end
                DBH: state <= RUN;
                RUN: begin
                    if (br_cfg != cfg_q) begin
                        state    <= DBL;
                        cfg_q    <= br_cfg;
                        iocs_q   <= 1'b1;
                        iorw_q   <= 1'b0;
                        ioaddr_q <= 2'b10;
                        drive_q  <= 1'b1;
                        dout_q   <= div_sel[7:0];
                    end else if (bus.rda && !full) begin
                        state     <= RD;
                        discard_q <= 1'b0;
                        iocs_q    <= 1'b1;
                    end else if (bus.tbr && !empty) begin
                        state    <= WR;
                        iocs_q   <= 1'b1;
                        iorw_q   <= 1'b0;
                        drive_q  <= 1'b1;
                        dout_q   <= mem[rd_ptr];
                    end else if (bus.rda) begin
                        // Full and transmit stalled: read the byte anyway to
                        // clear rda, then drop it.
                        state     <= RD;
                        discard_q <= 1'b1;
                        iocs_q    <= 1'b1;
                    end
                end
                RD: begin
                    state <= GAP;
                    if (discard_q && overrun_q != 8'hFF)
                        overrun_q <= overrun_q + 8'd1;
                end
                WR:      state <= GAP;
                GAP:     state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

    // FIFO pointers and occupancy; the sequencer never pushes and pops together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
        end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
        end
    end

    // FIFO storage, written with the byte sampled at the end of the RD cycle.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= swap_case(databus);
    end
endmodule

// File: tb/tb_spart_echo_ctrl.sv
// Bench: two controllers (plain and case-swapping) driven in lockstep by one
// SPART model; echoed bytes are checked against per-instance scoreboards.
module tb_spart_echo_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] br_cfg = 2'b01;
    logic       rda = 1'b0, tbr = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    wire  [7:0] db0, db1;
    logic [2:0] fc0, fc1;
    logic [7:0] ov0, ov1;
    logic [7:0] q0[$], q1[$];
    logic [7:0] e0, e1;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    spart_echo_ctrl_if bus0();
    spart_echo_ctrl_if bus1();
    assign bus0.rda = rda;
    assign bus0.tbr = tbr;
    assign bus1.rda = rda;
    assign bus1.tbr = tbr;

    // SPART model drives the data bus only during a receive-buffer read.
    assign db0 = (bus0.iocs && bus0.iorw && bus0.ioaddr == 2'b00) ? rx_byte : 8'hzz;
    assign db1 = (bus1.iocs && bus1.iorw && bus1.ioaddr == 2'b00) ? rx_byte : 8'hzz;

    spart_echo_ctrl #(.CLK_HZ(50000000), .FIFO_DEPTH(4), .CASE_SWAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .br_cfg(br_cfg), .bus(bus0.master),
        .databus(db0), .fifo_count(fc0), .overrun_cnt(ov0));
    spart_echo_ctrl #(.CLK_HZ(50000000), .FIFO_DEPTH(4), .CASE_SWAP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .br_cfg(br_cfg), .bus(bus1.master),
        .databus(db1), .fifo_count(fc1), .overrun_cnt(ov1));

    function automatic logic [7:0] ref_swap(input logic [7:0] b);
        if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))
            return b ^ 8'h20;
        return b;
    endfunction

    // Scoreboard for the plain instance: every TX write pops the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus0.iocs && !bus0.iorw && bus0.ioaddr == 2'b00) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL echo0 unexpected write got 0x%02h, none expected", db0);
            end else begin
                e0 = q0.pop_front();
                if (db0 !== e0) begin
                    errors++;
                    $display("FAIL echo0 got 0x%02h want 0x%02h", db0, e0);
                end
            end
        end
    end

    // Scoreboard for the case-swapping instance.
    always @(negedge clk) begin
        if (rst_n && bus1.iocs && !bus1.iorw && bus1.ioaddr == 2'b00) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL echo1 unexpected write got 0x%02h, none expected", db1);
            end else begin
                e1 = q1.pop_front();
                if (db1 !== e1) begin
                    errors++;
                    $display("FAIL echo1 got 0x%02h want 0x%02h", db1, e1);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Expect DBL(lo) then DBH(hi) then iocs low.
    task automatic wait_prog(input logic [7:0] lo, input logic [7:0] hi, input string nm);
        int n = 0;
        while (!(bus0.iocs && bus0.ioaddr == 2'b10) && n < 20) begin tick(); n++; end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL %s divisor low timeout got none want 0x%02h", nm, lo);
            return;
        end
        if ({bus0.iorw, bus1.iocs, bus1.iorw, db0, db1} !== {1'b0, 1'b1, 1'b0, lo, lo}) begin
            errors++;
            $display("FAIL %s dbl got iorw=%b data=0x%02h/0x%02h want iorw=0 data=0x%02h",
                     nm, bus0.iorw, db0, db1, lo);
        end
        tick();
        checks++;
        if ({bus0.iocs, bus0.iorw, bus0.ioaddr, db0, db1} !== {1'b1, 1'b0, 2'b11, hi, hi}) begin
            errors++;
            $display("FAIL %s dbh got cs=%b rw=%b addr=%b data=0x%02h want 1 0 11 0x%02h",
                     nm, bus0.iocs, bus0.iorw, bus0.ioaddr, db0, hi);
        end
        tick();
        checks++;
        if ({bus0.iocs, bus0.iorw, bus1.iocs} !== 3'b010) begin
            errors++;
            $display("FAIL %s run got cs=%b rw=%b want cs=0 rw=1", nm, bus0.iocs, bus0.iorw);
        end
    endtask

    // Present a byte with rda until the controller reads it; returns at the RD cycle.
    task automatic send_byte(input logic [7:0] b, input bit keep);
        int n = 0;
        tick();
        rx_byte = b;
        rda = 1'b1;
        while (!(bus0.iocs && bus0.iorw && bus0.ioaddr == 2'b00) && n < 50) begin tick(); n++; end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL rx_read timeout for byte 0x%02h", b);
        end
        rda = 1'b0;
        if (keep) begin
            q0.push_back(b);
            q1.push_back(ref_swap(b));
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin tick(); n++; end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s drain timeout, %0d/%0d bytes still expected want 0", nm, q0.size(), q1.size());
        end
        repeat (3) tick();
        checks++;
        if ({fc0, fc1} !== 6'd0) begin
            errors++;
            $display("FAIL %s fifo_count got %0d/%0d want 0", nm, fc0, fc1);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({bus0.iocs, bus0.iorw, bus0.ioaddr, fc0, ov0} !== {1'b0, 1'b1, 2'b00, 3'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset got cs=%b rw=%b addr=%b cnt=%0d ovr=%0d want 0 1 00 0 0",
                     bus0.iocs, bus0.iorw, bus0.ioaddr, fc0, ov0);
        end
        rst_n = 1'b1;
        wait_prog(8'h44, 8'h01, "init_9600");
    endtask

    task automatic test_echo();
        tbr = 1'b1;
        send_byte(8'h41, 1'b1);
        tick();
        checks++;
        if (fc0 !== 3'd1) begin
            errors++;
            $display("FAIL echo_count after read got %0d want 1", fc0);
        end
        tick();
        tick();
        checks++;
        if ({bus0.iocs, bus0.iorw, bus0.ioaddr} !== 4'b1000) begin
            errors++;
            $display("FAIL echo_latency got cs=%b rw=%b addr=%b want WR at read+3",
                     bus0.iocs, bus0.iorw, bus0.ioaddr);
        end
        drain("echo");
    endtask

    task automatic test_case_swap();
        tbr = 1'b1;
        send_byte(8'h61, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h31, 1'b1);
        drain("case_swap");
    endtask

    task automatic test_overrun();
        logic [7:0] bytes [5] = '{8'h10, 8'h62, 8'h43, 8'h7E, 8'h55};
        tbr = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(bytes[i], i < 4);
        repeat (3) tick();
        checks++;
        if ({fc0, fc1, ov0, ov1, 3'(q0.size())} !== {3'd4, 3'd4, 8'd1, 8'd1, 3'd4}) begin
            errors++;
            $display("FAIL overrun got cnt=%0d/%0d ovr=%0d/%0d pending=%0d want 4 4 1 1 4",
                     fc0, fc1, ov0, ov1, q0.size());
        end
        tbr = 1'b1;
        drain("overrun");
    endtask

    task automatic test_rebaud();
        tbr = 1'b0;
        send_byte(8'h20, 1'b1);
        send_byte(8'h71, 1'b1);
        repeat (3) tick();
        br_cfg = 2'b11;
        wait_prog(8'h50, 8'h00, "rebaud_38400");
        checks++;
        if ({fc0, fc1} !== {3'd2, 3'd2}) begin
            errors++;
            $display("FAIL rebaud fifo_count got %0d/%0d want 2", fc0, fc1);
        end
        tbr = 1'b1;
        drain("rebaud");
    endtask

    task automatic test_reset_mid_wr();
        int n = 0;
        tbr = 1'b0;
        send_byte(8'h4B, 1'b1);
        send_byte(8'h6C, 1'b1);
        tbr = 1'b1;
        while (!(bus0.iocs && !bus0.iorw && bus0.ioaddr == 2'b00) && n < 50) begin tick(); n++; end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL midreset no WR cycle seen within 50 cycles");
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus0.iocs, bus0.iorw, bus1.iocs, fc0, fc1, ov0, ov1} !==
            {1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL midreset got cs=%b rw=%b cnt=%0d ovr=%0d want cs=0 rw=1 cnt=0 ovr=0",
                     bus0.iocs, bus0.iorw, fc0, ov0);
        end
        q0.delete();
        q1.delete();
        br_cfg = 2'b01;
        repeat (2) tick();
        rst_n = 1'b1;
        wait_prog(8'h44, 8'h01, "midreset_reprog");
        send_byte(8'h7A, 1'b1);
        drain("midreset_echo");
    endtask

    initial begin
        test_reset();
        test_echo();
        test_case_swap();
        test_overrun();
        test_rebaud();
        test_reset_mid_wr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spart_echo_ctrl.md
Name: spart_echo_ctrl

Overview:
Parametrised SPART host-side controller that programs the baud divisor, then echoes every received byte back through the SPART over the iocs/iorw/ioaddr/databus register bus. It replaces the fixed single-byte driver. Additions over that driver:
- an internal FIFO decoupling receive from transmit;
- runtime baud selection via br_cfg, with automatic reprogramming;
- an optional case-swap mode;
- overrun accounting.

It sits between the board switches/top level and the spart instance.

Parameters:
CLK_HZ, 50000000, system clock frequency used to compute baud divisors
FIFO_DEPTH, 4, echo buffer depth in bytes; power of 2, minimum 2
CASE_SWAP, 0, 0 = echo unchanged; 1 = swap case of ASCII letters (A-Z <-> a-z) before push

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
br_cfg  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400
iocs  out  1  SPART chip select, high only during a bus access cycle
iorw  out  1  1 = read, 0 = write
ioaddr  out  2  00 = TX/RX buffer, 01 = status, 10 = DB low, 11 = DB high
databus  inout  8  driven only in write cycles, otherwise 'z
rda  in  1  SPART receive data available
tbr  in  1  SPART transmit buffer ready
fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
overrun_cnt  out  8  saturating count of bytes dropped because the FIFO was full

Behaviour:
- Divisor: DIV(baud) = CLK_HZ/(16*baud) - 1, integer division. At 50 MHz the values are:
  - 4800 = 650 (0x028A)
  - 9600 = 324 (0x0144)
  - 19200 = 161 (0x00A1)
  - 38400 = 80 (0x0050)
- FSM states: INIT, DBL, DBH, RUN, RD, WR, GAP. Every bus access lasts exactly one cycle.
- INIT (reset state): iocs=0, iorw=1, ioaddr=00, databus='z. Next cycle -> DBL.
- DBL: iocs=1, iorw=0, ioaddr=10, databus=DIV[7:0]. Latches br_cfg into cfg_q. -> DBH.
- DBH: iocs=1, iorw=0, ioaddr=11, databus=DIV[15:8], where DIV is computed from cfg_q. -> RUN.
- RUN: iocs=0. Conditions are evaluated in priority order:
  - (1) br_cfg != cfg_q -> DBL. Reprogramming takes effect only from RUN and never aborts an access. The FIFO is preserved.
  - (2) rda && !full -> RD.
  - (3) tbr && !empty -> WR.
  - (4) rda && full -> RD in discard mode.
  - (5) otherwise stay in RUN.
- RD: iocs=1, iorw=1, ioaddr=00. databus is sampled at the clock edge ending the cycle.
  - Normal mode: push (case-swapped if CASE_SWAP=1; non-letters unchanged).
  - Discard mode: byte dropped; overrun_cnt increments and saturates at 255.
  - -> GAP.
- WR: iocs=1, iorw=0, ioaddr=00, databus = FIFO head. Pop at the edge ending the cycle. -> GAP.
- GAP: one idle cycle (iocs=0) so SPART rda/tbr can update. -> RUN.
- Receive has priority over transmit, except that when the FIFO is full and tbr=1 the write goes first, so a byte is discarded only when transmit cannot drain.
- FIFO: circular buffer.
  - Pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
  - fifo_count updates the cycle after a push or pop.
  - A push and a pop never occur in the same cycle, since the FSM serialises them.
- Latency: a byte read in cycle N can appear on databus in a WR cycle no earlier than N+3 (GAP, RUN, WR).
- Reset mid-operation: everything returns immediately to the INIT outputs. FIFO is emptied; fifo_count=0; overrun_cnt=0; cfg_q=00; databus released. After reset the divisor is always reprogrammed.
- iorw defaults to 1 whenever iocs=0, so the SPART is never accidentally written.

Test Plan:
1. Reset release, br_cfg=01, CLK_HZ=50M -> DBL cycle writes 0x44 at ioaddr=10, then DBH writes 0x01 at ioaddr=11; iocs high exactly 2 cycles; then RUN with iocs=0.
2. rda pulse with SPART returning 0x41, tbr=1, CASE_SWAP=0 -> RD cycle, GAP, RUN, then WR driving 0x41 at ioaddr=00, iorw=0; fifo_count goes 0->1->0.
3. CASE_SWAP=1: receive 0x61, 0x5A, 0x31 -> transmits 0x41, 0x7A, 0x31 in order.
4. tbr=0, five bytes received with FIFO_DEPTH=4 -> fifo_count=4, fifo 5th byte read from SPART but dropped, overrun_cnt=1; raise tbr -> first four bytes echoed in FIFO order.
5. In RUN with 2 bytes buffered, change br_cfg 01->11 -> DBL/DBH write 0x50/0x00; fifo_count stays 2; echo then resumes.
6. Assert rst_n=0 during a WR cycle -> iocs=0 and databus='z immediately; fifo_count=0 and overrun_cnt=0; on release the divisor sequence repeats.
